// File: rtl/fma_stim_pkg.sv
// fma_stim_pkg -- shared constants and types for the FMA stimulus generator.
//
// Contents:
//   LFSR_POLY     Galois feedback mask applied when the shifted-out bit is 1
//   SEED_SPREAD   golden-ratio constant that decorrelates per-channel seeds
//   state_t       run-control FSM states
//   HALF_SPECIALS half-precision special operands, selected by a 3-bit index
//   channel_seed  derives the non-zero seed of LFSR channel k from a base seed
//
// Optional feature macro: FMA_STIM_SPECIALS_EN (table is only referenced then).
package fma_stim_pkg;

  localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
  localparam logic [31:0] SEED_SPREAD = 32'h9E37_79B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // +0, -0, +inf, -inf, qNaN, max normal, min subnormal, min normal
  localparam logic [15:0] HALF_SPECIALS [8] = '{
    16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
    16'h7E00, 16'h7BFF, 16'h0001, 16'h0400
  };

  // An all-zero Galois LFSR never leaves zero, so a zero result is remapped.
  function automatic logic [31:0] channel_seed(input logic [31:0] base, input int k);
    logic [31:0] v;
    v = base ^ (32'(k) * SEED_SPREAD);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

endpackage

// File: rtl/stim_lfsr.sv
// stim_lfsr -- one 32-bit Galois LFSR with synchronous load and step.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-low; state returns to RESET_VALUE
//   load        load load_value (wins over step)
//   load_value  value loaded on load
//   step        advance the sequence by one position
//   state       current LFSR contents
module stim_lfsr
  import fma_stim_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] state_reg;
  logic [31:0] state_next;

  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = load_value;
    end else if (step) begin
      state_next = {1'b0, state_reg[31:1]} ^ (state_reg[0] ? LFSR_POLY : 32'h0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RESET_VALUE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/fma_stim_gen.sv
// fma_stim_gen -- seedable, back-pressure-aware pseudo-random stimulus source
// for FMA datapaths. NOPS operand LFSRs plus one control LFSR; vectors are
// offered over valid/ready for a programmed count.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   start, count        begin a run of count vectors (IDLE only)
//   seed_load, seed     reload every LFSR from seed (IDLE only)
//   ready / valid       handshake; LFSRs step on valid && ready
//   op                  NOPS x WIDTH packed operands, channel k at op[k*WIDTH +: WIDTH]
//   mul, add, negr, negz, roundmode   FMA control fields
//   vec_idx             index of the current vector in the run
//   busy                high while running
//   done                one-cycle pulse when a run finishes
//
// Optional feature macro: FMA_STIM_SPECIALS_EN -- every eighth vector
// (vec_idx[2:0] == 7) carries half-precision special operands; WIDTH must be 16.
module fma_stim_gen
  import fma_stim_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NOPS   = 3,
  parameter logic [31:0] SEED   = 32'h0000_0001,
  parameter int unsigned COUNTW = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COUNTW-1:0]     count,
  input  logic                  seed_load,
  input  logic [31:0]           seed,
  input  logic                  ready,
  output logic                  valid,
  output logic [NOPS*WIDTH-1:0] op,
  output logic                  mul,
  output logic                  add,
  output logic                  negr,
  output logic                  negz,
  output logic [1:0]            roundmode,
  output logic [COUNTW-1:0]     vec_idx,
  output logic                  busy,
  output logic                  done
);

  state_t            state_reg, state_next;
  logic [COUNTW-1:0] remaining_reg, remaining_next;
  logic [COUNTW-1:0] vec_idx_reg, vec_idx_next;
  logic              lfsr_step;
  logic              lfsr_load;
  logic [31:0]       lfsr_state [NOPS+1];
  logic [NOPS:0]     lfsr_unused;

  // Seed loading shares the IDLE cycle with start, so a same-cycle start
  // issues its first vector from the freshly loaded seed.
  assign lfsr_load = (state_reg == IDLE) && seed_load;
  assign lfsr_step = (state_reg == RUN) && ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      vec_idx_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      vec_idx_reg   <= vec_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    vec_idx_next   = vec_idx_reg;
    valid          = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_next     = RUN;
            remaining_next = count;
            vec_idx_next   = '0;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (ready) begin
          vec_idx_next = vec_idx_reg + COUNTW'(1);
          if (remaining_reg == COUNTW'(1)) begin
            state_next = DONE;
          end else begin
            remaining_next = remaining_reg - COUNTW'(1);
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign vec_idx = vec_idx_reg;

  genvar gi;
  generate
    for (gi = 0; gi <= NOPS; gi++) begin : g_lfsr
      stim_lfsr #(
        .RESET_VALUE(channel_seed(SEED, gi))
      ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load       (lfsr_load),
        .load_value (channel_seed(seed, gi)),
        .step       (lfsr_step),
        .state      (lfsr_state[gi])
      );
      // Only the low bits of each LFSR reach an output; fold the rest away.
      assign lfsr_unused[gi] = ^lfsr_state[gi];
    end

`ifdef FMA_STIM_SPECIALS_EN
    if (WIDTH != 16) begin : g_width_check
      $error("fma_stim_gen: special-value table needs WIDTH == 16");
    end
    for (gi = 0; gi < NOPS; gi++) begin : g_op
      assign op[gi*WIDTH +: WIDTH] = (vec_idx_reg[2:0] == 3'b111)
                                   ? HALF_SPECIALS[lfsr_state[gi][10:8]]
                                   : lfsr_state[gi][WIDTH-1:0];
    end
`else
    for (gi = 0; gi < NOPS; gi++) begin : g_op
      assign op[gi*WIDTH +: WIDTH] = lfsr_state[gi][WIDTH-1:0];
    end
`endif
  endgenerate

  // Control word comes from the extra LFSR channel.
  assign mul       = lfsr_state[NOPS][0];
  assign add       = lfsr_state[NOPS][1];
  assign negr      = lfsr_state[NOPS][2];
  assign negz      = lfsr_state[NOPS][3];
  assign roundmode = lfsr_state[NOPS][5:4];

endmodule

// File: tb/tb_fma_stim_gen.sv
// tb_fma_stim_gen -- directed self-checking bench for fma_stim_gen with
// default parameters (WIDTH=16, NOPS=3, SEED=1, COUNTW=16). A small LFSR
// reference model tracks the expected operand/control stream.
// Optional feature macro: FMA_STIM_SPECIALS_EN (model applies special values).
module tb_fma_stim_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] count;
  logic        seed_load;
  logic [31:0] seed;
  logic        ready;
  logic        valid;
  logic [47:0] op;
  logic        mul, add, negr, negz;
  logic [1:0]  roundmode;
  logic [15:0] vec_idx;
  logic        busy;
  logic        done;
  logic [5:0]  ctrl;

  int checks = 0;
  int errors = 0;

  logic [31:0] m [4];

  localparam logic [15:0] SPC [8] = '{
    16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
    16'h7E00, 16'h7BFF, 16'h0001, 16'h0400
  };

  fma_stim_gen #(
    .WIDTH(16), .NOPS(3), .SEED(32'h0000_0001), .COUNTW(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .seed_load (seed_load),
    .seed      (seed),
    .ready     (ready),
    .valid     (valid),
    .op        (op),
    .mul       (mul),
    .add       (add),
    .negr      (negr),
    .negz      (negz),
    .roundmode (roundmode),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done)
  );

  assign ctrl = {roundmode, negz, negr, add, mul};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] spread(input logic [31:0] s, input int k);
    logic [31:0] v;
    v = s ^ (32'(k) * 32'h9E37_79B9);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  task automatic model_load(input logic [31:0] s);
    for (int k = 0; k < 4; k++) m[k] = spread(s, k);
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) m[k] = lfsr_next(m[k]);
  endtask

  function automatic logic [47:0] exp_op(input int idx);
    logic [47:0] v;
    bit specials_on;
`ifdef FMA_STIM_SPECIALS_EN
    specials_on = 1'b1;
`else
    specials_on = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      v[k*16 +: 16] = (specials_on && (idx % 8 == 7)) ? SPC[m[k][10:8]] : m[k][15:0];
    end
    return v;
  endfunction

  // mode 0: ready held high; mode 1: ready 1,0,0 repeating;
  // mode 2: ready high, start and seed_load pulsed during the first RUN cycle.
  task automatic do_run(input int n, input int mode, input bit with_seed, input logic [31:0] seed_val);
    int hs, cyc, idx;
    bit r, stalled;
    logic [47:0] prev_op;
    start = 1'b1;
    count = 16'(n);
    ready = 1'b1;
    if (with_seed) begin
      seed_load = 1'b1;
      seed      = seed_val;
      model_load(seed_val);
    end
    @(negedge clk);
    start = 1'b0;
    seed_load = 1'b0;
    hs = 0; cyc = 0; idx = 0; stalled = 1'b0; prev_op = '0;
    while (hs < n && cyc < 200) begin
      check("run_valid", valid, 1);
      check("run_busy", busy, 1);
      check("run_vec_idx", vec_idx, idx);
      check("run_op", op, exp_op(idx));
      check("run_ctrl", ctrl, m[3][5:0]);
      if (stalled) check("stall_op", op, prev_op);
      r = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      if (mode == 2 && cyc == 0) begin
        start = 1'b1; count = 16'd9; seed_load = 1'b1; seed = 32'h0;
      end
      ready = r;
      prev_op = op;
      stalled = !r;
      @(negedge clk);
      start = 1'b0;
      seed_load = 1'b0;
      if (r) begin
        hs++; idx++;
        model_step();
      end
      cyc++;
    end
    $display("run n=%0d mode=%0d handshakes=%0d cycles=%0d", n, mode, hs, cyc);
    check("run_handshakes", hs, n);
    check("end_valid", valid, 0);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    @(negedge clk);
    check("done_clear", done, 0);
    check("idle_valid", valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; count = '0; seed_load = 1'b0; seed = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_load(32'h1);
    @(negedge clk);
    // reset state
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vec_idx", vec_idx, 0);
    check("rst_x", op[15:0], 16'h0001);
    check("rst_y", op[31:16], 16'h79B8);
    check("rst_z", op[47:32], 16'hF373);
    check("rst_ctrl", ctrl, 6'h2A);
    $display("reset state op=%h ctrl=%h", op, ctrl);

    // two-vector run, hand-computed sequence of channel 0
    start = 1'b1; count = 16'd2; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("v0_valid", valid, 1);
    check("v0_x", op[15:0], 16'h0001);
    check("v0_idx", vec_idx, 0);
    check("v0_op", op, exp_op(0));
    $display("vec 0 op=%h ctrl=%h", op, ctrl);
    model_step();
    @(negedge clk);
    check("v1_valid", valid, 1);
    check("v1_x", op[15:0], 16'h0003);
    check("v1_idx", vec_idx, 1);
    check("v1_op", op, exp_op(1));
    $display("vec 1 op=%h ctrl=%h", op, ctrl);
    model_step();
    @(negedge clk);
    check("v_end_valid", valid, 0);
    check("v_end_done", done, 1);
    @(negedge clk);
    check("v_done_pulse", done, 0);

    // back-pressure: ready 1,0,0,...
    do_run(5, 1, 1'b0, 32'h0);

    // zero-length run
    start = 1'b1; count = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("z_valid", valid, 0);
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    @(negedge clk);
    check("z_done_clear", done, 0);
    check("z_valid2", valid, 0);
    check("z_op_kept", op, exp_op(5));
    $display("zero-count run done pulse seen");

    // seed_load in IDLE with seed 0
    seed_load = 1'b1; seed = 32'h0;
    @(negedge clk);
    seed_load = 1'b0;
    model_load(32'h0);
    check("s0_x", op[15:0], 16'h0001);
    check("s0_y", op[31:16], 16'h79B9);
    check("s0_z", op[47:32], 16'hF372);
    check("s0_ctrl", ctrl, 6'h2B);
    $display("seed 0 load op=%h ctrl=%h", op, ctrl);

    // start and seed_load during RUN are ignored
    do_run(3, 2, 1'b0, 32'h0);

    // seed_load together with start
    do_run(4, 0, 1'b1, 32'hDEAD_BEEF);

    // reset in the middle of a 10-vector run
    model_load(32'h1);
    seed_load = 1'b1; seed = 32'h1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b1; count = 16'd10; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      model_step();
    end
    check("mid_idx", vec_idx, 3);
    check("mid_op", op, exp_op(3));
    #2 reset = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    check("arst_idx", vec_idx, 0);
    check("arst_x", op[15:0], 16'h0001);
    $display("async reset mid-run valid=%b busy=%b", valid, busy);
    @(negedge clk);
    reset = 1'b1;
    model_load(32'h1);
    do_run(1, 0, 1'b0, 32'h0);

    // long run spanning two special slots when the feature is built in
    do_run(16, 0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
